// File: rtl/dbf_lut_loader_pkg.sv
// Shared widths and FSM encoding for the DBF delay-LUT loader and channel blocks.
package dbf_lut_loader_pkg;

  localparam int unsigned DBF_ADDR_WD   = 10;
  localparam int unsigned DBF_DATA_WD   = 16;
  localparam int unsigned DBF_N_CH      = 64;
  localparam int unsigned DBF_CH_WD     = 6;
  localparam int unsigned DBF_LUT_DEPTH = 1 << DBF_ADDR_WD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } load_state_e;

endpackage

// File: rtl/dbf_lut_loader_if.sv
// Host word stream plus LUT write bus between host, loader and the DBF channel array.
interface dbf_lut_loader_if #(
  parameter int unsigned ADDR_WD = 10,
  parameter int unsigned DATA_WD = 16,
  parameter int unsigned CH_WD   = 6
);
  logic [DATA_WD-1:0] host_din;
  logic               host_valid;
  logic               host_ready;
  logic [DATA_WD-1:0] lut_wdata;
  logic [ADDR_WD-1:0] dbf_lut_addr;
  logic               dbf_lut_we;
  logic [CH_WD-1:0]   lut_ch_sel;

  // Loader side: consumes host words, drives the LUT write bus.
  modport slave (
    input  host_din, host_valid,
    output host_ready, lut_wdata, dbf_lut_addr, dbf_lut_we, lut_ch_sel
  );

  // Host side: produces words, observes the write bus.
  modport master (
    output host_din, host_valid,
    input  host_ready, lut_wdata, dbf_lut_addr, dbf_lut_we, lut_ch_sel
  );
endinterface

// File: rtl/dbf_lut_loader_lut_addr_gen.sv
// Nested LUT address / channel counter: address-minor, channel-major, with wrap and last-word flag.
module lut_addr_gen #(
  parameter int unsigned ADDR_WD = 10,
  parameter int unsigned N_CH    = 64,
  parameter int unsigned CH_WD   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  output logic [ADDR_WD-1:0] addr,
  output logic [CH_WD-1:0]   ch,
  output logic               last_c
);

  localparam logic [ADDR_WD-1:0] ADDR_MAX = '1;
  localparam logic [CH_WD-1:0]   CH_MAX   = CH_WD'(N_CH - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      addr <= '0;
      ch   <= '0;
    end else if (adv) begin
      if (addr == ADDR_MAX) begin
        addr <= '0;
        ch   <= (ch == CH_MAX) ? '0 : ch + CH_WD'(1);
      end else begin
        addr <= addr + ADDR_WD'(1);
      end
    end
  end

  assign last_c = (addr == ADDR_MAX) && (ch == CH_MAX);

endmodule

// File: rtl/dbf_lut_loader.sv
// Sequences a host word stream into every DBF channel LUT and flags when a full image is resident.
module dbf_lut_loader
  import dbf_lut_loader_pkg::*;
#(
  parameter int unsigned ADDR_WD = DBF_ADDR_WD,
  parameter int unsigned DATA_WD = DBF_DATA_WD,
  parameter int unsigned N_CH    = DBF_N_CH,
  parameter int unsigned CH_WD   = DBF_CH_WD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_req,
  input  logic                    abort,
  input  logic                    tx_en,
  dbf_lut_loader_if.slave         bus,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    lut_ready
);

  load_state_e        state_q, state_d;
  logic               accept_c;
  logic               last_c;
  logic               busy_d, done_d, ready_d;
  logic [ADDR_WD-1:0] gen_addr;
  logic [CH_WD-1:0]   gen_ch;
  logic [DATA_WD-1:0] wdata_q;
  logic [ADDR_WD-1:0] addr_q;
  logic [CH_WD-1:0]   ch_q;
  logic               we_q;

  // Abort also drops ready so the word offered in the abort cycle is never written.
  assign bus.host_ready = (state_q == ST_LOAD) & ~tx_en & ~abort;
  assign accept_c       = bus.host_valid & bus.host_ready;

  lut_addr_gen #(
    .ADDR_WD (ADDR_WD),
    .N_CH    (N_CH),
    .CH_WD   (CH_WD)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_IDLE),
    .adv    (accept_c),
    .addr   (gen_addr),
    .ch     (gen_ch),
    .last_c (last_c)
  );

  // Next state and next registered status outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (load_req && !abort)     state_d = ST_LOAD;
      ST_LOAD: if (abort)                  state_d = ST_IDLE;
               else if (accept_c && last_c) state_d = ST_DONE;
      ST_DONE:                             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_LOAD);
    done_d  = (state_d == ST_DONE);
    ready_d = lut_ready;
    if (state_q == ST_DONE) ready_d = 1'b1;
    // A new load invalidates the resident image.
    if (state_q == ST_IDLE && state_d == ST_LOAD) ready_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      lut_ready <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      addr_q    <= '0;
      ch_q      <= '0;
    end else begin
      state_q   <= state_d;
      load_busy <= busy_d;
      load_done <= done_d;
      lut_ready <= ready_d;
      we_q      <= accept_c;
      if (accept_c) begin
        wdata_q <= bus.host_din;
        addr_q  <= gen_addr;
        ch_q    <= gen_ch;
      end
    end
  end

  assign bus.lut_wdata    = wdata_q;
  assign bus.dbf_lut_addr = addr_q;
  assign bus.lut_ch_sel   = ch_q;
  assign bus.dbf_lut_we   = we_q;

endmodule
